// File: rtl/msrv32_pkg.sv
// Shared constants and types for the msrv32 integer register file.
// The optional write-to-read bypass is enabled by defining MSRV32_RF_BYPASS_EN.
package msrv32_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/msrv32_rf_read_port.sv
// One asynchronous read port: x0 zero-detect and array read, plus the
// write-to-read bypass when MSRV32_RF_BYPASS_EN is defined.
module msrv32_rf_read_port
  import msrv32_pkg::*;
(
  input  logic [XLEN-1:0]   rf [NUM_REGS],
  input  logic [ADDR_W-1:0] rs_addr,
`ifdef MSRV32_RF_BYPASS_EN
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_data,
`endif
  output logic [XLEN-1:0]   rs_data
);

  // Read mux; a non-zero rs_addr equal to rd_addr also implies rd_addr is non-zero
  always_comb begin
    rs_data = '0;
    if (rs_addr == ZERO_REG) begin
      rs_data = '0;
    end
`ifdef MSRV32_RF_BYPASS_EN
    else if (!rst && wr_en && (rd_addr == rs_addr)) begin
      rs_data = rd_data;
    end
`endif
    else begin
      rs_data = rf[rs_addr];
    end
  end

endmodule

// File: rtl/msrv32_integer_file.sv
// Architectural integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero. Bypass macro: MSRV32_RF_BYPASS_EN.
module msrv32_integer_file
  import msrv32_pkg::*;
(
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic [ADDR_W-1:0] rs_1_addr_in,
  input  logic [ADDR_W-1:0] rs_2_addr_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic              wr_en_in,
  input  logic [XLEN-1:0]   rd_in,
  output logic [XLEN-1:0]   rs_1_out,
  output logic [XLEN-1:0]   rs_2_out
);

  xlen_t rf_r [NUM_REGS];

  // Storage update: reset clears every entry and wins over a same-edge write
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_r[i] <= '0;
      end
    end else if (wr_en_in && (rd_addr_in != ZERO_REG)) begin
      rf_r[rd_addr_in] <= rd_in;
    end
  end

  msrv32_rf_read_port u_read_port_1 (
    .rf      (rf_r),
    .rs_addr (rs_1_addr_in),
`ifdef MSRV32_RF_BYPASS_EN
    .rst     (ms_riscv32_mp_rst_in),
    .wr_en   (wr_en_in),
    .rd_addr (rd_addr_in),
    .rd_data (rd_in),
`endif
    .rs_data (rs_1_out)
  );

  msrv32_rf_read_port u_read_port_2 (
    .rf      (rf_r),
    .rs_addr (rs_2_addr_in),
`ifdef MSRV32_RF_BYPASS_EN
    .rst     (ms_riscv32_mp_rst_in),
    .wr_en   (wr_en_in),
    .rd_addr (rd_addr_in),
    .rd_data (rd_in),
`endif
    .rs_data (rs_2_out)
  );

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Scoreboard bench for msrv32_integer_file: stimulus queues expected read data,
// a negedge monitor pops and compares. Honours MSRV32_RF_BYPASS_EN.
module tb_msrv32_integer_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_1_addr;
  logic [4:0]  rs_2_addr;
  logic [4:0]  rd_addr;
  logic        wr_en;
  logic [31:0] rd_data;
  logic [31:0] rs_1_data;
  logic [31:0] rs_2_data;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  msrv32_integer_file dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .rs_1_addr_in         (rs_1_addr),
    .rs_2_addr_in         (rs_2_addr),
    .rd_addr_in           (rd_addr),
    .wr_en_in             (wr_en),
    .rd_in                (rd_data),
    .rs_1_out             (rs_1_data),
    .rs_2_out             (rs_2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: read ports are combinational, so compare mid-cycle
  always @(negedge clk) begin
    exp_t item;
    while (sb.size() > 0) begin
      item = sb.pop_front();
      n_checks++;
      if (rs_1_data !== item.e1) begin
        n_fails++;
        $display("FAIL %s rs_1_out got %h expected %h", item.name, rs_1_data, item.e1);
      end
      n_checks++;
      if (rs_2_data !== item.e2) begin
        n_fails++;
        $display("FAIL %s rs_2_out got %h expected %h", item.name, rs_2_data, item.e2);
      end
    end
  end

  // Drive one cycle's inputs just after a rising edge; optionally queue expectations
  task automatic cycle(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                       input logic chk, input string name,
                       input logic [31:0] e1, input logic [31:0] e2);
    exp_t item;
    @(posedge clk);
    #1;
    rst = r; wr_en = we; rd_addr = wa; rd_data = wd;
    rs_1_addr = a1; rs_2_addr = a2;
    if (chk) begin
      item.name = name; item.e1 = e1; item.e2 = e2;
      sb.push_back(item);
    end
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    cycle(1'b0, 1'b1, wa, wd, 5'd0, 5'd0, 1'b0, "", 32'h0, 32'h0);
  endtask

  task automatic rd(input string name, input logic [4:0] a1, input logic [4:0] a2,
                    input logic [31:0] e1, input logic [31:0] e2);
    cycle(1'b0, 1'b0, 5'd0, 32'h0, a1, a2, 1'b1, name, e1, e2);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] same_cycle_exp;
    rst = 1'b1; wr_en = 1'b0; rd_addr = 5'd0; rd_data = 32'h0;
    rs_1_addr = 5'd0; rs_2_addr = 5'd0;

    rd("reset_state", 5'd1, 5'd31, 32'h0, 32'h0);

    // Test 1: preload, reset mid-program, everything reads zero
    wr(5'd5, 32'hDEAD_BEEF);
    wr(5'd6, 32'h0BAD_F00D);
    rd("preload_x5", 5'd5, 5'd6, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b1, "pre_reset_hold",
          32'hDEAD_BEEF, 32'h0BAD_F00D);
    rd("reset_clear_x5", 5'd5, 5'd6, 32'h0, 32'h0);
    for (int i = 1; i < 32; i++) begin
      rd("reset_clear_all", 5'(i), 5'(32 - i), 32'h0, 32'h0);
    end

    // Test 2: basic write/read and a few distinct patterns
    wr(5'd10, 32'h1234_5678);
    rd("basic_x10", 5'd10, 5'd10, 32'h1234_5678, 32'h1234_5678);
    wr(5'd31, 32'h8000_0001);
    wr(5'd1, 32'h0000_FFFF);
    rd("pattern_x31_x1", 5'd31, 5'd1, 32'h8000_0001, 32'h0000_FFFF);
    rd("retain_x10", 5'd1, 5'd10, 32'h0000_FFFF, 32'h1234_5678);

    // Test 3: x0 write discarded and never bypassed
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, "x0_no_bypass",
          32'h0, 32'h0);
    rd("x0_protect", 5'd0, 5'd10, 32'h0, 32'h1234_5678);

    // Test 4: wr_en low holds state
    wr(5'd7, 32'hA5A5_A5A5);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 5'd7, 32'h0, 5'd7, 5'd0, 1'b1, "wr_disabled",
            32'hA5A5_A5A5, 32'h0);
    end
    rd("wr_disabled_after", 5'd7, 5'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

    // Test 5: reset beats a same-edge write; bypass is suppressed under reset
    wr(5'd3, 32'h0000_0077);
    cycle(1'b1, 1'b1, 5'd3, 32'h0000_0055, 5'd3, 5'd7, 1'b1, "rst_no_bypass",
          32'h0000_0077, 32'hA5A5_A5A5);
    rd("rst_vs_write", 5'd3, 5'd7, 32'h0, 32'h0);

    // Test 6: same-cycle read of the address being written
    wr(5'd9, 32'h0000_0011);
`ifdef MSRV32_RF_BYPASS_EN
    same_cycle_exp = 32'h0000_0022;
`else
    same_cycle_exp = 32'h0000_0011;
`endif
    cycle(1'b0, 1'b1, 5'd9, 32'h0000_0022, 5'd9, 5'd8, 1'b1, "same_cycle_read",
          same_cycle_exp, 32'h0);
    rd("after_edge_x9", 5'd9, 5'd9, 32'h0000_0022, 32'h0000_0022);

    cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, "", 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/msrv32_integer_file.md
Name: msrv32_integer_file

Overview:
- Architectural integer register file for the msrv32 core. It is the consumer of the writeback-select output.
- Holds x0..x31, each 32 bits wide.
- Two asynchronous read ports feed the operand path.
- One synchronous write port is driven by the writeback mux result, the destination address and the write enable from the writeback stage.
- x0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers. Must be a power of two.
- ADDR_W, 5, register address width, equal to log2(NUM_REGS).

Ports:
- ms_riscv32_mp_clk_in, input, 1, core clock. All state updates on its rising edge.
- ms_riscv32_mp_rst_in, input, 1, synchronous active-high reset.
- rs_1_addr_in, input, ADDR_W, read port 1 address.
- rs_2_addr_in, input, ADDR_W, read port 2 address.
- rd_addr_in, input, ADDR_W, write address from the writeback stage.
- wr_en_in, input, 1, write enable from the writeback stage. It is already gated by flush/trap upstream.
- rd_in, input, XLEN, write data (the writeback mux result).
- rs_1_out, output, XLEN, read data for port 1.
- rs_2_out, output, XLEN, read data for port 2.

Behaviour:
- Reset
  - Reset is synchronous and active-high. When ms_riscv32_mp_rst_in=1 at a rising edge, all NUM_REGS entries become 0.
  - After that edge, rs_1_out and rs_2_out read 0 for every address.
  - Reset has priority over a write in the same cycle; the write is dropped.
  - Reset asserted mid-program discards all register contents, with no partial clear.
- Write
  - At a rising edge with rst=0, wr_en_in=1 and rd_addr_in!=0: reg[rd_addr_in] <= rd_in.
  - Writes to x0 are silently discarded.
  - wr_en_in=0 leaves all state unchanged, whatever rd_addr_in and rd_in are.
- Read
  - Reads are purely combinational, with zero latency: rs_N_out = reg[rs_N_addr_in].
  - Address 0 always returns 0, regardless of any storage contents.
  - Both ports may read the same address; both outputs are then identical.
- Write latency: data written at edge k is visible on the read ports from just after edge k. The next cycle's read of that address returns the new value.
- Same-cycle read of the address being written (feature off): returns the old value until the edge.
- Out-of-range addresses cannot occur (ADDR_W matches NUM_REGS). No wrap handling is needed.
- No X propagation: storage is fully defined after the first reset.

Optional Feature:
- Macro: MSRV32_RF_BYPASS_EN.
- Defined:
  - Each read port has a write-to-read bypass. If wr_en_in=1, rd_addr_in!=0 and rs_N_addr_in==rd_addr_in, then rs_N_out=rd_in in the same cycle, before the edge.
  - The bypass is suppressed while ms_riscv32_mp_rst_in=1; the port returns stored contents.
  - x0 is never bypassed.
- Undefined: no bypass. A same-cycle read returns the stored (old) value.

Decomposition:
- Package msrv32_pkg holds:
  - XLEN, NUM_REGS and ADDR_W constants.
  - ZERO_REG constant (5'd0).
  - reg_addr_t and xlen_t typedefs.
- Sub-module msrv32_rf_read_port is natural:
  - Instantiated twice.
  - Performs the zero-detect, the array read and (under MSRV32_RF_BYPASS_EN) the bypass compare and mux.
  - Keeps both ports structurally identical.

Test Plan:
1. Reset clear: preload x5=32'hDEAD_BEEF, assert rst for 1 cycle -> rs_1_out=0 with rs_1_addr_in=5, and every address 1..31 reads 0.
2. Basic write/read: wr_en=1, rd_addr=10, rd_in=32'h1234_5678, edge -> next cycle rs_1_addr=10 and rs_2_addr=10 both return 32'h1234_5678.
3. x0 protection: wr_en=1, rd_addr=0, rd_in=32'hFFFF_FFFF, edge -> rs_1_addr=0 returns 0. The bypass does not fire when the feature is enabled.
4. Write-disabled: preload x7=32'hA5A5_A5A5, then wr_en=0, rd_addr=7, rd_in=32'h0 for 3 edges -> x7 still reads 32'hA5A5_A5A5.
5. Reset vs write collision: rst=1 and wr_en=1, rd_addr=3, rd_in=32'h55 on the same edge -> x3 reads 0 afterwards.
6. Same-cycle read of write address: x9=32'h11; drive wr_en=1, rd_addr=9, rd_in=32'h22, rs_1_addr=9 before the edge.
   - Feature off -> rs_1_out=32'h11.
   - Feature on -> rs_1_out=32'h22.
   - After the edge, both builds read 32'h22.
